// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: signed 32x32 -> 64 in 32 EXEC cycles.
// Optional overflow flag output ovf is enabled by defining MUL_OVF_EN.
module booth_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] result,
    output logic        busy,
    output logic        op_done
`ifdef MUL_OVF_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] m_reg;
    logic [32:0] a_reg;
    logic [31:0] qr_reg;
    logic        q1_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] result_reg;
    logic        busy_reg;
    logic        op_done_reg;
`ifdef MUL_OVF_EN
    logic        ovf_reg;
`endif

    logic [32:0] m_ext;
    logic [32:0] m_inv;
    logic [32:0] addend;
    logic        carry_in;
    logic [32:0] sum;
    logic [32:0] carry;
    logic [32:0] a_next;
    logic [31:0] qr_next;
    logic        q1_next;
    logic [63:0] prod_next;

    // Accumulator is one bit wider than M so that subtracting -2^31 cannot overflow.
    assign m_ext = {m_reg[31], m_reg};

    generate
        for (genvar gi = 0; gi < 33; gi++) begin : g_inv
            assign m_inv[gi] = ~m_ext[gi];
        end
    endgenerate

    always_comb begin
        addend   = '0;
        carry_in = 1'b0;
        case ({qr_reg[0], q1_reg})
            2'b01: addend = m_ext;
            2'b10: begin
                addend   = m_inv;
                carry_in = 1'b1;
            end
            default: addend = '0;
        endcase
    end

    assign carry[0] = carry_in;

    generate
        for (genvar gi = 0; gi < 33; gi++) begin : g_add
            assign sum[gi] = a_reg[gi] ^ addend[gi] ^ carry[gi];
            if (gi < 32) begin : g_carry
                assign carry[gi+1] = (a_reg[gi] & addend[gi]) |
                                     (carry[gi] & (a_reg[gi] ^ addend[gi]));
            end
        end
    endgenerate

    assign a_next    = {sum[32], sum[32:1]};
    assign qr_next   = {sum[0], qr_reg[31:1]};
    assign q1_next   = qr_reg[0];
    assign prod_next = {a_next[31:0], qr_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            m_reg       <= '0;
            a_reg       <= '0;
            qr_reg      <= '0;
            q1_reg      <= 1'b0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            busy_reg    <= 1'b0;
            op_done_reg <= 1'b0;
`ifdef MUL_OVF_EN
            ovf_reg     <= 1'b0;
`endif
        end else if (op_clear) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            busy_reg    <= 1'b0;
            op_done_reg <= 1'b0;
`ifdef MUL_OVF_EN
            ovf_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (op_start) begin
                        state_reg   <= EXEC;
                        m_reg       <= multiplicand;
                        a_reg       <= '0;
                        qr_reg      <= multiplier;
                        q1_reg      <= 1'b0;
                        cnt_reg     <= '0;
                        busy_reg    <= 1'b1;
                        op_done_reg <= 1'b0;
                    end
                end
                EXEC: begin
                    a_reg   <= a_next;
                    qr_reg  <= qr_next;
                    q1_reg  <= q1_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_reg   <= DONE;
                        result_reg  <= prod_next;
                        busy_reg    <= 1'b0;
                        op_done_reg <= 1'b1;
`ifdef MUL_OVF_EN
                        ovf_reg     <= !((&prod_next[63:31]) || !(|prod_next[63:31]));
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result  = result_reg;
    assign busy    = busy_reg;
    assign op_done = op_done_reg;
`ifdef MUL_OVF_EN
    assign ovf     = ovf_reg;
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases plus random
// operands checked against a plain-arithmetic signed product model.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] result;
    logic        busy;
    logic        op_done;
`ifdef MUL_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    booth_mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .busy         (busy),
        .op_done      (op_done)
`ifdef MUL_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint sm;
        longint sq;
        sm = longint'($signed(m));
        sq = longint'($signed(q));
        return sm * sq;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] m, input logic [31:0] q);
        longint p;
        longint lim;
        p   = longint'(ref_mul(m, q));
        lim = 64'sd2147483648;
        return (p >= lim) || (p < -lim);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        tick();
        op_start     = 1'b0;
    endtask

    // pre = busy cycles already consumed by the caller after the start edge.
    task automatic wait_done(input string tag, input logic [31:0] m, input logic [31:0] q,
                             input logic [63:0] exp_r, input logic exp_ovf, input int pre,
                             input logic [63:0] prev_r);
        int cycles;
        bit held;
        cycles = pre;
        held   = 1'b1;
        while (busy === 1'b1 && op_done !== 1'b1 && cycles < 100) begin
            if (result !== prev_r) held = 1'b0;
            cycles++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(cycles), 64'd32);
        check({tag, "_result_held"}, 64'(held), 64'd1);
        check({tag, "_done"}, 64'(op_done), 64'd1);
        check({tag, "_result"}, result, exp_r);
`ifdef MUL_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf model value");
`endif
        $display("op %s m=%h q=%h result=%h cycles=%0d", tag, m, q, result, cycles);
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp_r, input logic exp_ovf);
        logic [63:0] prev_r;
        prev_r = result;
        start_op(m, q);
        wait_done(tag, m, q, exp_r, exp_ovf, 0, prev_r);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(op_done), 64'd0);
        check({tag, "_result"}, result, 64'd0);
`ifdef MUL_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
    endtask

    task automatic watch_no_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (op_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] rm;
        logic [31:0] rq;
        logic [63:0] prev_r;

        reset        = 1'b1;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check_cleared("reset");

        // First start coincides with the first edge after reset is released.
        reset = 1'b0;
        run_op("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);

        tick();
        tick();
        tick();
        check("done_hold_flag", 64'(op_done), 64'd1);
        check("done_hold_result", result, 64'h0000_0000_0000_000F);

        run_op("sign_7x-3", 32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("sign_-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);

        // Simultaneous start and clear from DONE: clear wins.
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        tick();
        op_start     = 1'b0;
        op_clear     = 1'b0;
        check_cleared("start_clear");
        tick();
        check("start_clear_stays_idle", 64'(busy), 64'd0);

        // Start requests and operand changes during EXEC are ignored.
        prev_r = result;
        start_op(32'd100, -32'sd200);
        for (int i = 0; i < 5; i++) begin
            op_start     = 1'b1;
            multiplicand = $urandom;
            multiplier   = $urandom;
            tick();
        end
        op_start = 1'b0;
        wait_done("ignored_start", 32'd100, -32'sd200, ref_mul(32'd100, -32'sd200), 1'b0, 5, prev_r);

        for (int i = 0; i < 8; i++) begin
            rm = $urandom;
            rq = (i % 2 == 0) ? $urandom : {{20{rm[0]}}, 12'($urandom)};
            run_op("random", rm, rq, ref_mul(rm, rq), ref_ovf(rm, rq));
        end

        // Abort on the 10th EXEC cycle.
        start_op(32'd12345, 32'd678);
        repeat (9) tick();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check_cleared("abort");
        watch_no_done("abort", 40);

        rm = $urandom;
        rq = $urandom;
        run_op("pre_reset", rm | 32'h1, rq | 32'h1, ref_mul(rm | 32'h1, rq | 32'h1),
               ref_ovf(rm | 32'h1, rq | 32'h1));

        // Reset on the 20th EXEC cycle, then a fresh operation.
        start_op(32'hDEAD_BEEF, 32'h1234_5678);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("mid_reset");
        watch_no_done("mid_reset", 40);
        run_op("after_reset", 32'd2, 32'd2, 64'd4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
